// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing one quad seven-segment display between requesters A and B,
// with a minimum ownership time measured in prescaler ticks.
module seg_display_arbiter #(
  parameter int unsigned PRESCALE_W = 20,
  parameter int unsigned HOLD_TICKS = 4,
  parameter logic [15:0] IDLE_VAL   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_a,
  input  logic [15:0] data_a,
  input  logic        req_b,
  input  logic [15:0] data_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic [3:0]  val3,
  output logic [3:0]  val2,
  output logic [3:0]  val1,
  output logic [3:0]  val0,
  output logic        disp_on,
  output logic        tick
);

  localparam int unsigned HOLD_W = (HOLD_TICKS < 2) ? 1 : $clog2(HOLD_TICKS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN_A = 2'd1,
    S_OWN_B = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] presc_q;
  logic                  tick_q;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic                  last_b_q, last_b_d;
  logic [15:0]           disp_q, disp_d;
  logic                  gnt_a_q, gnt_b_q, disp_on_q;
  logic                  hold_ok;

  // Ownership may be taken away only once the hold time has fully elapsed.
  assign hold_ok = (HOLD_TICKS == 0) || (32'(hold_q) >= HOLD_TICKS);

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    last_b_d = last_b_q;
    disp_d   = IDLE_VAL;

    case (state_q)
      S_IDLE: begin
        if (req_a && req_b) state_d = last_b_q ? S_OWN_A : S_OWN_B;
        else if (req_a)     state_d = S_OWN_A;
        else if (req_b)     state_d = S_OWN_B;
      end
      S_OWN_A: begin
        if (!req_a)                state_d = req_b ? S_OWN_B : S_IDLE;
        else if (req_b && hold_ok) state_d = S_OWN_B;
      end
      S_OWN_B: begin
        if (!req_b)                state_d = req_a ? S_OWN_A : S_IDLE;
        else if (req_a && hold_ok) state_d = S_OWN_A;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      hold_d = '0;
      if (state_d == S_OWN_A)      last_b_d = 1'b0;
      else if (state_d == S_OWN_B) last_b_d = 1'b1;
    end else if (tick_q && (state_q != S_IDLE) && (32'(hold_q) < HOLD_TICKS)) begin
      hold_d = hold_q + HOLD_W'(1);
    end

    // Display follows the upcoming owner's live data every cycle.
    case (state_d)
      S_OWN_A: disp_d = data_a;
      S_OWN_B: disp_d = data_b;
      default: disp_d = IDLE_VAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      hold_q    <= '0;
      last_b_q  <= 1'b1;
      disp_q    <= IDLE_VAL;
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      disp_on_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_q + PRESCALE_W'(1);
      tick_q    <= &presc_q;
      hold_q    <= hold_d;
      last_b_q  <= last_b_d;
      disp_q    <= disp_d;
      gnt_a_q   <= (state_d == S_OWN_A);
      gnt_b_q   <= (state_d == S_OWN_B);
      disp_on_q <= (state_d != S_IDLE);
    end
  end

  assign gnt_a   = gnt_a_q;
  assign gnt_b   = gnt_b_q;
  assign disp_on = disp_on_q;
  assign tick    = tick_q;
  assign val3    = disp_q[15:12];
  assign val2    = disp_q[11:8];
  assign val1    = disp_q[7:4];
  assign val0    = disp_q[3:0];

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench for seg_display_arbiter: directed scenarios then random traffic,
// checked against an owner/hold/tick reference model.
module tb_seg_display_arbiter;

  localparam int HT  = 2;
  localparam int PER = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_a, req_b;
  logic [15:0] data_a, data_b;
  logic        gnt_a, gnt_b, disp_on, tick;
  logic [3:0]  val3, val2, val1, val0;

  seg_display_arbiter #(
    .PRESCALE_W(2),
    .HOLD_TICKS(HT),
    .IDLE_VAL  (16'h0000)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_a  (req_a),
    .data_a (data_a),
    .req_b  (req_b),
    .data_b (data_b),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b),
    .val3   (val3),
    .val2   (val2),
    .val1   (val1),
    .val0   (val0),
    .disp_on(disp_on),
    .tick   (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ga;
    logic        gb;
    logic        on;
    logic        tk;
    logic [15:0] v;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owner 0 = nobody, 1 = A, 2 = B; edges counts clocks since reset.
  int m_owner = 0;
  int m_last  = 2;
  int m_hold  = 0;
  int m_edges = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Predict the outcome of the coming edge from current inputs, then advance one clock.
  task automatic step();
    exp_t e;
    int   nxt;
    bit   tick_now;
    if (!rst_n) begin
      m_owner = 0; m_last = 2; m_hold = 0; m_edges = 0;
      e.ga = 0; e.gb = 0; e.on = 0; e.tk = 0; e.v = 16'h0000;
    end else begin
      tick_now = (m_edges > 0) && (m_edges % PER == 0);
      nxt = m_owner;
      if (m_owner == 0) begin
        if (req_a && req_b) nxt = (m_last == 1) ? 2 : 1;
        else if (req_a)     nxt = 1;
        else if (req_b)     nxt = 2;
      end else begin
        bit mine  = (m_owner == 1) ? req_a : req_b;
        bit other = (m_owner == 1) ? req_b : req_a;
        int oth   = 3 - m_owner;
        if (!mine)                     nxt = other ? oth : 0;
        else if (other && m_hold >= HT) nxt = oth;
      end
      if (nxt != m_owner) begin
        m_hold = 0;
        if (nxt != 0) m_last = nxt;
      end else if (tick_now && m_owner != 0 && m_hold < HT) begin
        m_hold++;
      end
      m_owner = nxt;
      m_edges++;
      e.ga = (nxt == 1);
      e.gb = (nxt == 2);
      e.on = (nxt != 0);
      e.tk = (m_edges % PER == 0);
      e.v  = (nxt == 1) ? data_a : (nxt == 2) ? data_b : 16'h0000;
    end
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  // Monitor: every output sample is popped against the predicted response.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("gnt_a",   16'(gnt_a),   16'(e.ga));
      check("gnt_b",   16'(gnt_b),   16'(e.gb));
      check("disp_on", 16'(disp_on), 16'(e.on));
      check("tick",    16'(tick),    16'(e.tk));
      check("vals",    {val3, val2, val1, val0}, e.v);
      check("one_grant", 16'(gnt_a & gnt_b), 16'h0000);
    end
  end

  initial begin
    rst_n = 1'b0; req_a = 1'b1; req_b = 1'b0;
    data_a = 16'h1234; data_b = 16'hBEEF;

    // Reset held with A requesting, then release.
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("gnt_after_reset", 16'(gnt_a), 16'h0001);
    check("vals_after_reset", {val3, val2, val1, val0}, 16'h1234);

    // Ties from IDLE: A first after reset, then B.
    req_a = 1'b0; rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    req_a = 1'b1; req_b = 1'b1;
    step();
    check("tie_first_a", {14'd0, gnt_b, gnt_a}, 16'h0001);
    req_a = 1'b0; req_b = 1'b0;
    step();
    req_a = 1'b1; req_b = 1'b1;
    step();
    check("tie_second_b", {14'd0, gnt_b, gnt_a}, 16'h0002);

    // Hold: A owns, B contends until two ticks have elapsed.
    req_a = 1'b0; req_b = 1'b0;
    repeat (2) step();
    req_a = 1'b1;
    step();
    req_b = 1'b1;
    for (int i = 0; i < 12 && !gnt_b; i++) step();
    check("hold_switch", {14'd0, gnt_b, gnt_a}, 16'h0002);
    step();

    // Early release and re-request.
    req_a = 1'b0; req_b = 1'b0;
    repeat (2) step();
    req_a = 1'b1;
    repeat (2) step();
    req_a = 1'b0;
    repeat (2) step();
    req_a = 1'b1;
    step();

    // Live data on B, then reset while owned.
    req_a = 1'b0; req_b = 1'b1; data_b = 16'h0001;
    repeat (2) step();
    data_b = 16'h0002;
    repeat (2) step();
    rst_n = 1'b0;
    step();
    check("reset_mid_own", 16'(gnt_b), 16'h0000);
    rst_n = 1'b1; req_b = 1'b0;
    step();

    // Random traffic with persistent requests and occasional resets.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(7) == 0) req_a = ~req_a;
      if ($urandom_range(7) == 0) req_b = ~req_b;
      if ($urandom_range(3) == 0) data_a = 16'($urandom);
      if ($urandom_range(3) == 0) data_b = 16'($urandom);
      rst_n = ($urandom_range(199) != 0);
      step();
    end

    rst_n = 1'b1; req_a = 1'b0; req_b = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d responses left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
